seq_load_arb: RTL and testbench
===============================

SEQ_LOAD_ARB -- requirements
Module: seq_load_arb

Interface
REQ-001 Parameter PACK, default 8: number of 3-bit base codes packed per write word.
REQ-002 Parameter ADDR_W, default 10: write address width.
REQ-003 Parameter LEN_W, default 16: sequence length counter width.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 s_valid  in  2  per-requester byte valid; bit 0 is the reference stream, bit 1 is the query stream.
REQ-008 s_data0, s_data1  in  8 each  ASCII base byte per requester.
REQ-009 s_last  in  2  per-requester flag marking the final byte of a sequence.
REQ-010 s_ready  out  2  per-requester byte accept.
REQ-011 wr_en  out  1  buffer write strobe.
REQ-012 wr_sel  out  1  target buffer: 0 reference, 1 query.
REQ-013 wr_addr  out  ADDR_W  word address.
REQ-014 wr_data  out  3*PACK  packed codes, with code i in bits [3i+2:3i].
REQ-015 done  out  1  one-cycle pulse at sequence end.
REQ-016 done_id  out  1  requester that finished.
REQ-017 done_len  out  LEN_W  base count of the finished sequence.

Function
REQ-018 Encoding: 0x41 'A' maps to 000, 0x43 'C' to 001, 0x47 'G' to 010, 0x54 'T' to 011, 0x4E 'N' to 100, and any other byte to 100.
REQ-019 States: IDLE, STREAM, FLUSH, DONE.
REQ-020 IDLE:
- if any s_valid bit is set, grant one requester and go to STREAM;
- if both bits are set, grant the requester not granted last (round-robin); the first grant after reset goes to requester 0.
REQ-021 The grant is locked for a whole sequence and is released only after DONE.
REQ-022 STREAM: s_ready[g] = 1 and the other s_ready bit = 0.
- Each handshake (s_valid[g] & s_ready[g]) stores the encoded byte in pack slot cnt, increments cnt and increments len.
REQ-023 When the handshake fills slot PACK-1:
- next cycle: wr_en = 1, wr_data = the packed word, wr_addr = current word pointer;
- the word pointer then increments, and cnt returns to 0.
REQ-024 Latency from the accepting edge of a word's final byte to the wr_en cycle is exactly 1 cycle; s_ready stays high, so there is no stall.
REQ-025 A handshake with s_last set ends the sequence.
- If the accepted byte filled slot PACK-1, go to DONE.
- Otherwise go to FLUSH.
REQ-026 FLUSH:
- s_ready = 0;
- write the partial word with unused slots padded to 100, in one cycle;
- then go to DONE.
REQ-027 DONE, one cycle:
- done = 1, done_id = g, done_len = len;
- reset cnt, len and the word pointer to 0, and record g as last grant;
- go to IDLE.
REQ-028 wr_sel = g for every write belonging to a sequence.
REQ-029 wr_addr wraps modulo 2^ADDR_W with no error indication.
REQ-030 len saturates at 2^LEN_W-1; bytes are still accepted and written.
REQ-031 The encoder is shared and is used only by the granted stream; the non-granted s_valid is ignored and its byte is not consumed.
REQ-032 wr_en, done and s_ready are low in IDLE.
REQ-033 An s_valid drop mid-sequence inserts idle cycles with no state change.

Reset
REQ-034 rst_n low asynchronously forces the following, including mid-sequence:
- state to IDLE;
- s_ready, wr_en, wr_sel, wr_addr, wr_data, done, done_id, done_len to 0;
- cnt, len and word pointer to 0;
- last grant to 1, so that requester 0 wins first.
REQ-035 A sequence interrupted by reset is discarded; no flush and no done occur.

Verification
REQ-036 Stream 0 sends "ACGTNACG" (PACK=8) with last on the final 'G':
- one write with wr_sel=0, wr_addr=0, wr_data codes 0,1,2,3,4,0,1,2;
- no flush;
- done with done_id=0 and done_len=8.
REQ-037 Stream 1 sends "TTX" with last:
- one flush write with wr_sel=1, wr_addr=0, codes 3,3,4,4,4,4,4,4;
- done_len=3.
REQ-038 Both s_valid set from reset: stream 0 is served fully, then stream 1; s_ready[1]=0 until stream 0's done pulse.
REQ-039 Stream 0 sends 20 bases back-to-back:
- writes at wr_addr 0 and 1 with no stall;
- the flush at wr_addr 2 holds 4 codes;
- done_len=20.
REQ-040 rst_n asserted after 5 bytes of a sequence:
- outputs are immediately 0 and no write occurs;
- a new 8-byte sequence then writes at wr_addr 0.

Source files
------------

// File: rtl/seq_load_arb.sv
// seq_load_arb -- two-requester sequence loader.
// Grants one of two byte streams (round-robin on contention), encodes each
// ASCII base to a 3-bit code, packs PACK codes per buffer word and writes
// them out. A sequence is closed by s_last; a partial final word is padded
// with code 100 and flushed before the done pulse.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   s_valid[1:0]       byte valid per requester (0 = reference, 1 = query)
//   s_data0/s_data1    ASCII base byte per requester
//   s_last[1:0]        final byte of sequence per requester
//   s_ready[1:0]       byte accept per requester
//   wr_en/wr_sel       buffer write strobe / target buffer (= granted id)
//   wr_addr/wr_data    word address / packed codes (code i at [3i+2:3i])
//   done/done_id       one-cycle end-of-sequence pulse / finishing requester
//   done_len           base count of the finished sequence (saturating)
module seq_load_arb #(
  parameter int PACK   = 8,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          s_valid,
  input  logic [7:0]          s_data0,
  input  logic [7:0]          s_data1,
  input  logic [1:0]          s_last,
  output logic [1:0]          s_ready,
  output logic                wr_en,
  output logic                wr_sel,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [3*PACK-1:0]   wr_data,
  output logic                done,
  output logic                done_id,
  output logic [LEN_W-1:0]    done_len
);

  localparam int CNT_W = (PACK > 1) ? $clog2(PACK) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_e;

  typedef logic [PACK-1:0][2:0] word_t;
  localparam word_t PAD_WORD = {PACK{3'b100}};

  state_e              state_q, state_d;
  logic                g_q;        // locked grant for the current sequence
  logic                last_q;     // grant of the previous sequence
  logic [CNT_W-1:0]    cnt_q;      // next free pack slot
  logic [LEN_W-1:0]    len_q;
  logic [ADDR_W-1:0]   ptr_q;
  word_t               pack_q;     // unfilled slots always hold the pad code
  word_t               word_d;
  logic                wr_en_q;
  logic                wr_sel_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  word_t               wr_data_q;

  logic                gnt_d;
  logic                hs;
  logic [7:0]          byte_sel;
  logic                last_sel;
  logic [2:0]          code;
  logic                slot_full;

  function automatic logic [2:0] enc(input logic [7:0] b);
    case (b)
      8'h41:   enc = 3'b000;
      8'h43:   enc = 3'b001;
      8'h47:   enc = 3'b010;
      8'h54:   enc = 3'b011;
      default: enc = 3'b100;   // 'N' and anything unrecognised
    endcase
  endfunction

  // Single shared encoder, fed only by the granted stream.
  assign byte_sel  = g_q ? s_data1 : s_data0;
  assign last_sel  = s_last[g_q];
  assign code      = enc(byte_sel);
  assign hs        = (state_q == STREAM) && s_valid[g_q];
  assign slot_full = (cnt_q == CNT_W'(PACK - 1));

  // On contention, favour the requester that did not go last.
  assign gnt_d = (&s_valid) ? ~last_q : s_valid[1];

  always_comb begin
    word_d        = pack_q;
    word_d[cnt_q] = code;
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (|s_valid) state_d = STREAM;
      STREAM: if (hs && last_sel) state_d = slot_full ? DONE : FLUSH;
      FLUSH:  state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    s_ready  = 2'b00;
    done     = 1'b0;
    done_id  = 1'b0;
    done_len = '0;
    case (state_q)
      STREAM: s_ready = g_q ? 2'b10 : 2'b01;
      DONE: begin
        done     = 1'b1;
        done_id  = g_q;
        done_len = len_q;
      end
      default: ;
    endcase
  end

  // ---------------- datapath ----------------
  // The write registers are loaded on the accepting edge, so a full word
  // appears one cycle later while streaming continues, and a partial word
  // appears during the FLUSH cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_q       <= 1'b0;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      len_q     <= '0;
      ptr_q     <= '0;
      pack_q    <= PAD_WORD;
      wr_en_q   <= 1'b0;
      wr_sel_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= 1'b0;
      if (state_q == IDLE && |s_valid) g_q <= gnt_d;
      if (hs) begin
        if (!(&len_q)) len_q <= len_q + 1'b1;
        if (slot_full || last_sel) begin
          wr_en_q   <= 1'b1;
          wr_sel_q  <= g_q;
          wr_addr_q <= ptr_q;
          wr_data_q <= word_d;
          ptr_q     <= ptr_q + 1'b1;
          cnt_q     <= '0;
          pack_q    <= PAD_WORD;
        end else begin
          cnt_q  <= cnt_q + 1'b1;
          pack_q <= word_d;
        end
      end
      if (state_q == DONE) begin
        cnt_q  <= '0;
        len_q  <= '0;
        ptr_q  <= '0;
        pack_q <= PAD_WORD;
        last_q <= g_q;
      end
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_sel  = wr_sel_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_seq_load_arb.sv
module tb_seq_load_arb;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        v0, v1, l0, l1;
  logic [7:0]  d0, d1;
  logic [1:0]  s_valid, s_last, s_ready;
  logic        wr_en, wr_sel, done, done_id;
  logic [9:0]  wr_addr;
  logic [23:0] wr_data;
  logic [15:0] done_len;

  assign s_valid = {v1, v0};
  assign s_last  = {l1, l0};

  seq_load_arb dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data0(d0), .s_data1(d1),
    .s_last(s_last), .s_ready(s_ready), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_addr(wr_addr), .wr_data(wr_data), .done(done), .done_id(done_id),
    .done_len(done_len)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0;
  bit          w_sel[$];
  logic [9:0]  w_addr[$];
  logic [23:0] w_data[$];
  int          w_cyc[$];
  bit          d_id[$];
  logic [15:0] d_len[$];
  int          d_cyc[$];
  int          r1_pre, both_rdy;
  int          hs_cyc[64];

  localparam logic [23:0] W_ACGTNACG = {3'd2,3'd1,3'd0,3'd4,3'd3,3'd2,3'd1,3'd0};
  localparam logic [23:0] W_TTX      = {3'd4,3'd4,3'd4,3'd4,3'd4,3'd4,3'd3,3'd3};
  localparam logic [23:0] W_GA       = {3'd4,3'd4,3'd4,3'd4,3'd4,3'd4,3'd0,3'd2};
  localparam logic [23:0] W_A4C4     = {3'd1,3'd1,3'd1,3'd1,3'd0,3'd0,3'd0,3'd0};
  localparam logic [23:0] W_G4T4     = {3'd3,3'd3,3'd3,3'd3,3'd2,3'd2,3'd2,3'd2};
  localparam logic [23:0] W_ACGT_P   = {3'd4,3'd4,3'd4,3'd4,3'd3,3'd2,3'd1,3'd0};
  localparam logic [23:0] W_T4A4     = {3'd0,3'd0,3'd0,3'd0,3'd3,3'd3,3'd3,3'd3};

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled away from the active edge.
  always @(negedge clk) if (rst_n) begin
    if (s_ready[1] && d_id.size() == 0) r1_pre++;
    if (&s_ready) both_rdy++;
    if (wr_en) begin
      w_sel.push_back(wr_sel); w_addr.push_back(wr_addr);
      w_data.push_back(wr_data); w_cyc.push_back(cyc);
    end
    if (done) begin
      d_id.push_back(done_id); d_len.push_back(done_len); d_cyc.push_back(cyc);
    end
  end

  task automatic clear_logs();
    w_sel.delete(); w_addr.delete(); w_data.delete(); w_cyc.delete();
    d_id.delete(); d_len.delete(); d_cyc.delete();
    r1_pre = 0; both_rdy = 0;
  endtask

  task automatic drive(input int id, input bit v, input byte b, input bit l);
    if (id == 0) begin v0 = v; d0 = b; l0 = l; end
    else         begin v1 = v; d1 = b; l1 = l; end
  endtask

  task automatic apply_reset();
    v0 = 0; v1 = 0; l0 = 0; l1 = 0; d0 = 0; d1 = 0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
  endtask

  // Sends s byte by byte, waiting for each handshake; optionally drops
  // valid for 3 cycles after byte gap_at.
  task automatic send_seq(input int id, input string s, input bit with_last, input int gap_at);
    int w;
    bit hs;
    for (int i = 0; i < s.len(); i++) begin
      drive(id, 1'b1, s[i], with_last && (i == s.len() - 1));
      w = 0; hs = 0;
      while (!hs && w < 100) begin
        @(negedge clk); hs = s_ready[id];
        if (hs) hs_cyc[i] = cyc;
        @(posedge clk); #1; w++;
      end
      if (!hs) begin
        checks++; errors++;
        $display("FAIL handshake_timeout id=%0d byte=%0d", id, i);
      end
      if (i == gap_at) begin
        drive(id, 1'b0, 8'h00, 1'b0);
        repeat (3) @(posedge clk); #1;
      end
    end
    drive(id, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic settle();
    repeat (4) @(posedge clk); #1;
  endtask

  task automatic test_reset();
    v0 = 0; v1 = 0; l0 = 0; l1 = 0; d0 = 0; d1 = 0;
    rst_n = 0;
    repeat (2) @(posedge clk); #1;
    checks++;
    if ({s_ready, wr_en, wr_sel, wr_addr, wr_data, done, done_id, done_len} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b we=%b sel=%b a=%0d d=%h dn=%b id=%b len=%0d want all 0",
               s_ready, wr_en, wr_sel, wr_addr, wr_data, done, done_id, done_len);
    end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_full_word();
    clear_logs();
    send_seq(0, "ACGTNACG", 1'b1, -1);
    settle();
    checks++;
    if (w_data.size() != 1) begin errors++; $display("FAIL fw_nwrites got %0d want 1", w_data.size()); end
    else begin
      checks++; if (w_sel[0] !== 1'b0) begin errors++; $display("FAIL fw_sel got %b want 0", w_sel[0]); end
      checks++; if (w_addr[0] !== 10'd0) begin errors++; $display("FAIL fw_addr got %0d want 0", w_addr[0]); end
      checks++; if (w_data[0] !== W_ACGTNACG) begin errors++; $display("FAIL fw_data got %h want %h", w_data[0], W_ACGTNACG); end
      checks++; if (w_cyc[0] !== hs_cyc[7] + 1) begin errors++; $display("FAIL fw_latency got %0d want %0d", w_cyc[0] - hs_cyc[7], 1); end
    end
    checks++;
    if (d_id.size() != 1) begin errors++; $display("FAIL fw_ndone got %0d want 1", d_id.size()); end
    else begin
      checks++; if (d_id[0] !== 1'b0) begin errors++; $display("FAIL fw_done_id got %b want 0", d_id[0]); end
      checks++; if (d_len[0] !== 16'd8) begin errors++; $display("FAIL fw_done_len got %0d want 8", d_len[0]); end
      if (w_cyc.size() == 1) begin
        checks++; if (d_cyc[0] !== w_cyc[0]) begin errors++; $display("FAIL fw_no_flush done_cyc=%0d want %0d", d_cyc[0], w_cyc[0]); end
      end
    end
  endtask

  task automatic test_flush_gap();
    clear_logs();
    send_seq(1, "TTX", 1'b1, 1);
    settle();
    checks++;
    if (w_data.size() != 1) begin errors++; $display("FAIL fl_nwrites got %0d want 1", w_data.size()); end
    else begin
      checks++; if (w_sel[0] !== 1'b1) begin errors++; $display("FAIL fl_sel got %b want 1", w_sel[0]); end
      checks++; if (w_addr[0] !== 10'd0) begin errors++; $display("FAIL fl_addr got %0d want 0", w_addr[0]); end
      checks++; if (w_data[0] !== W_TTX) begin errors++; $display("FAIL fl_data got %h want %h", w_data[0], W_TTX); end
    end
    checks++;
    if (d_id.size() != 1) begin errors++; $display("FAIL fl_ndone got %0d want 1", d_id.size()); end
    else begin
      checks++; if (d_id[0] !== 1'b1) begin errors++; $display("FAIL fl_done_id got %b want 1", d_id[0]); end
      checks++; if (d_len[0] !== 16'd3) begin errors++; $display("FAIL fl_done_len got %0d want 3", d_len[0]); end
      if (w_cyc.size() == 1) begin
        checks++; if (d_cyc[0] !== w_cyc[0] + 1) begin errors++; $display("FAIL fl_done_after_flush got %0d want %0d", d_cyc[0], w_cyc[0] + 1); end
      end
    end
  endtask

  task automatic test_arbitration();
    apply_reset();
    clear_logs();
    fork
      send_seq(0, "ACGTNACG", 1'b1, -1);
      send_seq(1, "GA", 1'b1, -1);
    join
    settle();
    checks++; if (r1_pre !== 0) begin errors++; $display("FAIL arb_ready1_early got %0d cycles want 0", r1_pre); end
    checks++; if (both_rdy !== 0) begin errors++; $display("FAIL arb_both_ready got %0d cycles want 0", both_rdy); end
    checks++;
    if (w_data.size() != 2 || d_id.size() != 2) begin
      errors++; $display("FAIL arb_counts got writes=%0d dones=%0d want 2 2", w_data.size(), d_id.size());
    end else begin
      checks++; if (w_sel[0] !== 1'b0 || w_data[0] !== W_ACGTNACG) begin errors++; $display("FAIL arb_first got sel=%b d=%h want 0 %h", w_sel[0], w_data[0], W_ACGTNACG); end
      checks++; if (w_sel[1] !== 1'b1 || w_addr[1] !== 10'd0 || w_data[1] !== W_GA) begin errors++; $display("FAIL arb_second got sel=%b a=%0d d=%h want 1 0 %h", w_sel[1], w_addr[1], w_data[1], W_GA); end
      checks++; if (d_id[0] !== 1'b0 || d_id[1] !== 1'b1) begin errors++; $display("FAIL arb_done_order got %b,%b want 0,1", d_id[0], d_id[1]); end
      checks++; if (d_len[1] !== 16'd2) begin errors++; $display("FAIL arb_len1 got %0d want 2", d_len[1]); end
    end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    send_seq(0, "AAAACCCCGGGGTTTTACGT", 1'b1, -1);
    settle();
    checks++; if (hs_cyc[19] - hs_cyc[0] !== 19) begin errors++; $display("FAIL b2b_stall got span %0d want 19", hs_cyc[19] - hs_cyc[0]); end
    checks++;
    if (w_data.size() != 3) begin errors++; $display("FAIL b2b_nwrites got %0d want 3", w_data.size()); end
    else begin
      checks++; if (w_addr[0] !== 10'd0 || w_addr[1] !== 10'd1 || w_addr[2] !== 10'd2) begin errors++; $display("FAIL b2b_addr got %0d,%0d,%0d want 0,1,2", w_addr[0], w_addr[1], w_addr[2]); end
      checks++; if (w_data[0] !== W_A4C4 || w_data[1] !== W_G4T4) begin errors++; $display("FAIL b2b_data got %h,%h want %h,%h", w_data[0], w_data[1], W_A4C4, W_G4T4); end
      checks++; if (w_data[2] !== W_ACGT_P) begin errors++; $display("FAIL b2b_flush got %h want %h", w_data[2], W_ACGT_P); end
      checks++; if (w_cyc[1] - w_cyc[0] !== 8 || w_cyc[0] !== hs_cyc[7] + 1) begin errors++; $display("FAIL b2b_timing got gap=%0d lat=%0d want 8 1", w_cyc[1] - w_cyc[0], w_cyc[0] - hs_cyc[7]); end
    end
    checks++;
    if (d_len.size() != 1 || d_len[0] !== 16'd20) begin errors++; $display("FAIL b2b_done_len got n=%0d len=%0d want 1 20", d_len.size(), (d_len.size() > 0) ? d_len[0] : 16'd0); end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    send_seq(0, "ACGTN", 1'b0, -1);
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    checks++;
    if ({s_ready, wr_en, wr_sel, wr_addr, wr_data, done, done_id, done_len} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs got rdy=%b we=%b a=%0d d=%h dn=%b len=%0d want all 0",
               s_ready, wr_en, wr_addr, wr_data, done, done_len);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    checks++; if (w_data.size() != 0 || d_id.size() != 0) begin errors++; $display("FAIL midrst_discard got writes=%0d dones=%0d want 0 0", w_data.size(), d_id.size()); end
    clear_logs();
    send_seq(0, "TTTTAAAA", 1'b1, -1);
    settle();
    checks++;
    if (w_data.size() != 1 || d_len.size() != 1) begin errors++; $display("FAIL midrst_counts got writes=%0d dones=%0d want 1 1", w_data.size(), d_len.size()); end
    else begin
      checks++; if (w_addr[0] !== 10'd0 || w_data[0] !== W_T4A4) begin errors++; $display("FAIL midrst_write got a=%0d d=%h want 0 %h", w_addr[0], w_data[0], W_T4A4); end
      checks++; if (d_len[0] !== 16'd8) begin errors++; $display("FAIL midrst_len got %0d want 8", d_len[0]); end
    end
  endtask

  task automatic test_idle_outputs();
    @(negedge clk);
    checks++;
    if (s_ready !== 2'b00 || wr_en !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL idle_outputs got rdy=%b we=%b dn=%b want 00 0 0", s_ready, wr_en, done);
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_flush_gap();
    test_arbitration();
    test_back_to_back();
    test_reset_mid();
    test_idle_outputs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
endmodule
